// File: rtl/mem_fill_pkg.sv
// Shared types for the memory fill block: fill pattern selection and FSM states.
package mem_fill_pkg;

    localparam int MODE_W = 2;

    // Pattern encodings as driven by the top controller on the mode port.
    typedef enum logic [MODE_W-1:0] {
        IDENTITY = 2'd0,
        CONST    = 2'd1,
        INCR     = 2'd2,
        DECR     = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_fill_datagen.sv
// Combinational pattern generator: word value for a given fill index.
module mem_fill_datagen
    import mem_fill_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  mode_t             mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [ADDR_W-1:0] index,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] index_ext;

    // Size cast zero-extends or truncates the index; all sums wrap at DATA_W.
    assign index_ext = DATA_W'(index);

    always_comb begin
        data = index_ext;
        unique case (mode)
            IDENTITY: data = index_ext;
            CONST:    data = seed;
            INCR:     data = seed + index_ext;
            DECR:     data = seed - index_ext;
        endcase
    end

endmodule

// File: rtl/mem_fill_fsm.sv
// Fills DEPTH consecutive RAM words with a selectable pattern, stallable by grant.
// Handshake: a write happens on every cycle where busy is high, the FSM is writing and grant=1.
module mem_fill_fsm
    import mem_fill_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [MODE_W-1:0] mode,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              grant,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              write_enable,
    output logic              busy,
    output logic              finish,
    output state_t            state_dbg
);

    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_depth_check
        $error("mem_fill_fsm: DEPTH must be in 1..2**ADDR_W");
    end

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] i_q, i_d;
    mode_t             mode_q, mode_d;
    logic [DATA_W-1:0] seed_q, seed_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            mode_q  <= IDENTITY;
            seed_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            mode_q  <= mode_d;
            seed_q  <= seed_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        mode_d       = mode_q;
        seed_d       = seed_q;
        write_enable = 1'b0;
        busy         = 1'b0;
        finish       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WRITE;
                    i_d     = '0;
                    mode_d  = mode_t'(mode);
                    seed_d  = fill_value;
                end
            end
            WRITE: begin
                busy         = 1'b1;
                write_enable = grant;
                if (grant) begin
                    if (i_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
            end
            DONE: begin
                busy    = 1'b1;
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address and data come straight from held registers, so they keep their
    // last values in IDLE and DONE; reset values make both read as zero.
    assign address   = i_q;
    assign state_dbg = state_q;

    mem_fill_datagen #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_datagen (
        .mode (mode_q),
        .seed (seed_q),
        .index(i_q),
        .data (data)
    );

endmodule
